// File: rtl/neuron_cache_fill.sv
// neuron_cache_fill: loads a column-major pixel stream into the 7-channel neuron line cache.
// Latency: an accepted beat is written one cycle later; fetch_start/layer_done align with that write.
// Backpressure: pixel_ready_o depends only on registers. It is low when no channel credit is free or no layer is filling.
// Ports: clk/layer_reset_n (async active-low), layer_start_i + picture/filter codes (layer config),
//        pixel_valid_i/pixel_i/pixel_ready_o (input stream), column_release_i (credit return),
//        cache_wr_o/wr_address_o/wr_channel_sel_o/wr_data_o (cache write port),
//        free_channels_o, fetch_start_o, layer_done_o (status).
module neuron_cache_fill #(
  parameter int DATA_WIDTH              = 8,
  parameter int CACHE_DEPTH_BIT_WIDTH   = 5,
  parameter int CACHE_CHANNELS          = 7,
  parameter int PICTURE_WIDTH_BIT_WIDTH = 5,
  parameter int FILTER_WIDTH_BIT_WIDTH  = 3
) (
  input  logic                               clk,
  input  logic                               layer_reset_n,
  input  logic                               layer_start_i,
  input  logic [CACHE_DEPTH_BIT_WIDTH-1:0]   picture_height_i,
  input  logic [PICTURE_WIDTH_BIT_WIDTH-1:0] picture_width_i,
  input  logic [FILTER_WIDTH_BIT_WIDTH-1:0]  filter_width_i,
  input  logic                               pixel_valid_i,
  input  logic [DATA_WIDTH-1:0]              pixel_i,
  output logic                               pixel_ready_o,
  input  logic                               column_release_i,
  output logic                               cache_wr_o,
  output logic [CACHE_DEPTH_BIT_WIDTH-1:0]   wr_address_o,
  output logic [CACHE_CHANNELS-1:0]          wr_channel_sel_o,
  output logic [DATA_WIDTH-1:0]              wr_data_o,
  output logic [$clog2(CACHE_CHANNELS+1)-1:0] free_channels_o,
  output logic                               fetch_start_o,
  output logic                               layer_done_o
);

  localparam int CREDIT_W = $clog2(CACHE_CHANNELS + 1);
  localparam logic [CREDIT_W-1:0]       CREDIT_MAX = CREDIT_W'(CACHE_CHANNELS);
  localparam logic [CACHE_CHANNELS-1:0] SEL_FIRST  = {1'b1, {(CACHE_CHANNELS-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t                             state;
  logic [CACHE_DEPTH_BIT_WIDTH-1:0]   height_q;
  logic [PICTURE_WIDTH_BIT_WIDTH-1:0] width_q;
  logic [FILTER_WIDTH_BIT_WIDTH-1:0]  filter_q;
  logic [CACHE_DEPTH_BIT_WIDTH-1:0]   row_cnt;
  logic [PICTURE_WIDTH_BIT_WIDTH-1:0] col_cnt;
  logic [CACHE_CHANNELS-1:0]          sel;
  logic [CREDIT_W-1:0]                credits;

  logic accept;
  logic col_done;

  assign pixel_ready_o   = (state == FILL) && (credits != '0);
  assign accept          = pixel_valid_i && pixel_ready_o;
  assign col_done        = accept && (row_cnt == height_q);
  assign free_channels_o = credits;
  assign layer_done_o    = (state == DONE);

  always_ff @(posedge clk or negedge layer_reset_n) begin
    if (!layer_reset_n) begin
      state            <= IDLE;
      height_q         <= '0;
      width_q          <= '0;
      filter_q         <= '0;
      row_cnt          <= '0;
      col_cnt          <= '0;
      sel              <= SEL_FIRST;
      credits          <= CREDIT_MAX;
      cache_wr_o       <= 1'b0;
      wr_address_o     <= '0;
      wr_channel_sel_o <= SEL_FIRST;
      wr_data_o        <= '0;
      fetch_start_o    <= 1'b0;
    end else begin
      cache_wr_o    <= accept;
      fetch_start_o <= 1'b0;
      if (accept) begin
        wr_address_o     <= row_cnt;
        wr_channel_sel_o <= sel;
        wr_data_o        <= pixel_i;
      end

      // A completion and a release in the same cycle cancel out. A completion
      // can only happen with credits != 0, so the decrement never wraps.
      if (col_done && !column_release_i) begin
        credits <= credits - 1'b1;
      end else if (!col_done && column_release_i && (credits != CREDIT_MAX)) begin
        credits <= credits + 1'b1;
      end

      case (state)
        IDLE, DONE: begin
          if (layer_start_i) begin
            height_q <= picture_height_i;
            width_q  <= picture_width_i;
            filter_q <= filter_width_i;
            row_cnt  <= '0;
            col_cnt  <= '0;
            sel      <= SEL_FIRST;
            credits  <= CREDIT_MAX;
            state    <= FILL;
          end
        end
        FILL: begin
          if (col_done) begin
            row_cnt <= '0;
            sel     <= {sel[0], sel[CACHE_CHANNELS-1:1]};
            col_cnt <= col_cnt + 1'b1;
            if (col_cnt == PICTURE_WIDTH_BIT_WIDTH'(filter_q)) begin
              fetch_start_o <= 1'b1;
            end
            if (col_cnt == width_q) begin
              state <= DONE;
            end
          end else if (accept) begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_cache_fill.sv
module tb_neuron_cache_fill;

  logic       clk = 1'b0;
  logic       layer_reset_n = 1'b0;
  logic       layer_start_i = 1'b0;
  logic [4:0] picture_height_i = '0;
  logic [4:0] picture_width_i = '0;
  logic [2:0] filter_width_i = '0;
  logic       pixel_valid_i = 1'b0;
  logic [7:0] pixel_i = '0;
  logic       pixel_ready_o;
  logic       column_release_i = 1'b0;
  logic       cache_wr_o;
  logic [4:0] wr_address_o;
  logic [6:0] wr_channel_sel_o;
  logic [7:0] wr_data_o;
  logic [2:0] free_channels_o;
  logic       fetch_start_o;
  logic       layer_done_o;

  int checks = 0;
  int errors = 0;

  neuron_cache_fill dut (
    .clk              (clk),
    .layer_reset_n    (layer_reset_n),
    .layer_start_i    (layer_start_i),
    .picture_height_i (picture_height_i),
    .picture_width_i  (picture_width_i),
    .filter_width_i   (filter_width_i),
    .pixel_valid_i    (pixel_valid_i),
    .pixel_i          (pixel_i),
    .pixel_ready_o    (pixel_ready_o),
    .column_release_i (column_release_i),
    .cache_wr_o       (cache_wr_o),
    .wr_address_o     (wr_address_o),
    .wr_channel_sel_o (wr_channel_sel_o),
    .wr_data_o        (wr_data_o),
    .free_channels_o  (free_channels_o),
    .fetch_start_o    (fetch_start_o),
    .layer_done_o     (layer_done_o)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(pixel_ready_o), 32'd0);
    check({tag, "_wr"},    32'(cache_wr_o), 32'd0);
    check({tag, "_addr"},  32'(wr_address_o), 32'd0);
    check({tag, "_sel"},   32'(wr_channel_sel_o), 32'h40);
    check({tag, "_data"},  32'(wr_data_o), 32'd0);
    check({tag, "_free"},  32'(free_channels_o), 32'd7);
    check({tag, "_fetch"}, 32'(fetch_start_o), 32'd0);
    check({tag, "_done"},  32'(layer_done_o), 32'd0);
  endtask

  task automatic check_write(input string tag, input logic [4:0] addr,
                             input logic [6:0] sel, input logic [7:0] data);
    check({tag, "_wr"},   32'(cache_wr_o), 32'd1);
    check({tag, "_addr"}, 32'(wr_address_o), 32'(addr));
    check({tag, "_sel"},  32'(wr_channel_sel_o), 32'(sel));
    check({tag, "_data"}, 32'(wr_data_o), 32'(data));
  endtask

  initial begin
    logic [6:0] exp_sel;

    // Reset state
    step();
    step();
    check_reset_values("rst");
    layer_reset_n = 1'b1;
    step();
    check_reset_values("idle");

    // Layer 1: height 3, width 2, filter 1; 12 continuous beats.
    // A layer_start during FILL (at beat 6) must be ignored.
    picture_height_i = 5'd3;
    picture_width_i  = 5'd2;
    filter_width_i   = 3'd1;
    layer_start_i    = 1'b1;
    step();
    layer_start_i = 1'b0;
    check("l1_ready", 32'(pixel_ready_o), 32'd1);
    check("l1_free0", 32'(free_channels_o), 32'd7);
    for (int i = 1; i <= 12; i++) begin
      pixel_valid_i = 1'b1;
      pixel_i       = 8'(i);
      layer_start_i = (i == 6);
      step();
      exp_sel = 7'b1000000 >> ((i - 1) / 4);
      check_write("l1_beat", 5'((i - 1) % 4), exp_sel, 8'(i));
      check("l1_fetch", 32'(fetch_start_o), 32'(i == 8));
      check("l1_done",  32'(layer_done_o), 32'(i == 12));
      check("l1_free",  32'(free_channels_o), 32'(7 - i / 4));
    end
    layer_start_i = 1'b0;
    pixel_valid_i = 1'b0;
    step();
    check("l1_idle_wr",  32'(cache_wr_o), 32'd0);
    check("l1_end_free", 32'(free_channels_o), 32'd4);
    check("l1_end_rdy",  32'(pixel_ready_o), 32'd0);
    check("l1_end_done", 32'(layer_done_o), 32'd1);

    // Layer 2: height 0, width 9, filter 2; credit stall then wrap.
    picture_height_i = 5'd0;
    picture_width_i  = 5'd9;
    filter_width_i   = 3'd2;
    layer_start_i    = 1'b1;
    step();
    layer_start_i = 1'b0;
    check("l2_start_free", 32'(free_channels_o), 32'd7);
    check("l2_start_done", 32'(layer_done_o), 32'd0);
    for (int k = 1; k <= 7; k++) begin
      pixel_valid_i = 1'b1;
      pixel_i       = 8'(8'h20 + k);
      step();
      exp_sel = 7'b1000000 >> (k - 1);
      check_write("l2_beat", 5'd0, exp_sel, 8'(8'h20 + k));
      check("l2_fetch", 32'(fetch_start_o), 32'(k == 3));
      check("l2_free",  32'(free_channels_o), 32'(7 - k));
    end
    check("l2_stall_rdy", 32'(pixel_ready_o), 32'd0);
    pixel_i = 8'h55;
    step();
    check("l2_held_wr",  32'(cache_wr_o), 32'd0);
    check("l2_held_rdy", 32'(pixel_ready_o), 32'd0);
    column_release_i = 1'b1;
    step();
    column_release_i = 1'b0;
    check("l2_rel_wr",   32'(cache_wr_o), 32'd0);
    check("l2_rel_rdy",  32'(pixel_ready_o), 32'd1);
    check("l2_rel_free", 32'(free_channels_o), 32'd1);
    step();
    check_write("l2_wrap", 5'd0, 7'b1000000, 8'h55);
    check("l2_wrap_free", 32'(free_channels_o), 32'd0);
    check("l2_wrap_rdy",  32'(pixel_ready_o), 32'd0);

    // Bring credits to 3, then complete a column with a release in the same cycle.
    pixel_valid_i    = 1'b0;
    column_release_i = 1'b1;
    step();
    step();
    step();
    check("l2_free3", 32'(free_channels_o), 32'd3);
    pixel_valid_i = 1'b1;
    pixel_i       = 8'h66;
    step();
    column_release_i = 1'b0;
    check_write("l2_simul", 5'd0, 7'b0100000, 8'h66);
    check("l2_simul_free", 32'(free_channels_o), 32'd3);
    check("l2_simul_done", 32'(layer_done_o), 32'd0);
    pixel_i = 8'h77;
    step();
    pixel_valid_i = 1'b0;
    check_write("l2_last", 5'd0, 7'b0010000, 8'h77);
    check("l2_last_done", 32'(layer_done_o), 32'd1);
    check("l2_last_free", 32'(free_channels_o), 32'd2);

    // Seven releases in DONE saturate at 7.
    column_release_i = 1'b1;
    for (int r = 0; r < 7; r++) step();
    column_release_i = 1'b0;
    check("l2_sat_free", 32'(free_channels_o), 32'd7);
    check("l2_sat_done", 32'(layer_done_o), 32'd1);
    check("l2_sat_rdy",  32'(pixel_ready_o), 32'd0);

    // Layer 3: valid toggles 1,0,1 -> two writes at contiguous addresses.
    picture_height_i = 5'd7;
    picture_width_i  = 5'd3;
    filter_width_i   = 3'd0;
    layer_start_i    = 1'b1;
    step();
    layer_start_i = 1'b0;
    pixel_valid_i = 1'b1;
    pixel_i       = 8'hA1;
    step();
    check_write("l3_w0", 5'd0, 7'b1000000, 8'hA1);
    pixel_valid_i = 1'b0;
    step();
    check("l3_gap_wr", 32'(cache_wr_o), 32'd0);
    pixel_valid_i = 1'b1;
    pixel_i       = 8'hA2;
    step();
    check_write("l3_w1", 5'd1, 7'b1000000, 8'hA2);
    check("l3_fetch", 32'(fetch_start_o), 32'd0);

    // Reset mid-column with valid still high: outputs drop immediately, no write follows.
    layer_reset_n = 1'b0;
    #2;
    check_reset_values("mid_rst");
    step();
    check("mid_rst_wr",  32'(cache_wr_o), 32'd0);
    check("mid_rst_rdy", 32'(pixel_ready_o), 32'd0);
    layer_reset_n    = 1'b1;
    pixel_valid_i    = 1'b0;
    picture_height_i = 5'd3;
    picture_width_i  = 5'd1;
    filter_width_i   = 3'd0;
    layer_start_i    = 1'b1;
    step();
    layer_start_i = 1'b0;
    pixel_valid_i = 1'b1;
    pixel_i       = 8'h77;
    step();
    pixel_valid_i = 1'b0;
    check_write("restart", 5'd0, 7'b1000000, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
